collatz_run_ctrl: RTL and testbench

Front-panel sequencer for the Collatz range datapath. It debounces the pushbuttons, launches a range run from the switch value, and waits for completion. It then lets the user browse the stored iteration counts by stepping the RAM read offset. It sits between the board I/O (KEY, SW) and the range datapath, and drives the hex-display registers.

---
 rtl/collatz_run_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_collatz_run_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_run_ctrl.sv
// collatz_run_ctrl
//   Front-panel sequencer for the Collatz range datapath. It synchronises and
//   debounces the four pushbuttons, launches a range run from the switch
//   value, waits for the datapath to finish, and then lets the user step
//   through the stored iteration counts.
//
// Ports
//   clk        system clock
//   reset_n    synchronous active-low reset
//   key_n[3:0] raw active-low buttons: [3]=run, [2]=home, [1]=prev, [0]=next
//   sw[9:0]    start value for the next run
//   go         one-cycle launch pulse to the datapath
//   start      base start value held for the datapath
//   done       datapath completion pulse (only honoured while running)
//   n          result read offset to the datapath RAM
//   count      RAM read data for offset n, one cycle of read latency
//   disp_value start + n, the value being shown
//   disp_iters iteration count for disp_value (count-1, floored at 0)
//   busy       run in progress
//   valid      browse results are valid
module collatz_run_ctrl #(
    parameter int RAM_WORDS       = 256,
    parameter int RAM_ADDR_BITS   = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               key_n,
    input  logic [9:0]               sw,
    output logic                     go,
    output logic [31:0]              start,
    input  logic                     done,
    output logic [RAM_ADDR_BITS-1:0] n,
    input  logic [15:0]              count,
    output logic [31:0]              disp_value,
    output logic [15:0]              disp_iters,
    output logic                     busy,
    output logic                     valid
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0]          DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0]          RP_DELAY  = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0]          RP_PERIOD = RP_W'(REPEAT_PERIOD);
    localparam logic [RAM_ADDR_BITS-1:0] N_LAST    = RAM_ADDR_BITS'(RAM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, BROWSE} state_t;

    state_t state;

    // Key levels are kept in the raw active-low sense: 1 = released.
    logic [3:0]      key_meta;
    logic [3:0]      key_sync;
    logic [3:0]      key_lvl;
    logic [3:0]      key_lvl_d;
    logic [DB_W-1:0] db_cnt [4];
    logic [RP_W-1:0] rpt_cnt [2];
    logic [1:0]      rpt_first;

    logic [3:0]      press_evt;
    logic [1:0]      rpt_evt;
    logic [3:0]      key_evt;
    logic [15:0]     iters_sat;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        press_evt = key_lvl_d & ~key_lvl;
        rpt_evt   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rpt_evt[i] = ~key_lvl[i] & ~press_evt[i] &
                         (rpt_cnt[i] == (rpt_first[i] ? RP_DELAY : RP_PERIOD));
        end
        key_evt   = press_evt | {2'b00, rpt_evt};
        iters_sat = (count == 16'd0) ? 16'd0 : count - 16'd1;
    end

    // Synchroniser, debounce and auto-repeat timing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: all state including the counter arrays is cleared; none of it is RAM.
            key_meta  <= 4'hF;
            key_sync  <= 4'hF;
            key_lvl   <= 4'hF;
            key_lvl_d <= 4'hF;
            rpt_first <= 2'b11;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
            for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            key_meta  <= key_n;
            key_sync  <= key_meta;
            key_lvl_d <= key_lvl;

            // The counter only advances while the synchronised level disagrees
            // with the accepted one; any agreement restarts the stability window.
            for (int i = 0; i < 4; i++) begin
                if (key_sync[i] == key_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]  <= '0;
                    key_lvl[i] <= ~key_lvl[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end

            // rpt_cnt holds the number of cycles since the last press or repeat event.
            for (int i = 0; i < 2; i++) begin
                if (key_lvl[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b1;
                end else if (press_evt[i]) begin
                    rpt_cnt[i]   <= RP_W'(1);
                    rpt_first[i] <= 1'b1;
                end else if (rpt_evt[i]) begin
                    rpt_cnt[i]   <= RP_W'(1);
                    rpt_first[i] <= 1'b0;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Run/browse sequencer with registered outputs and display registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            go         <= 1'b0;
            start      <= '0;
            n          <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            disp_value <= '0;
            disp_iters <= '0;
        end else begin
            go <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_evt[3]) begin
                        state <= LAUNCH;
                        go    <= 1'b1;
                        start <= {22'b0, sw};
                        n     <= '0;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state <= RUN;
                end
                RUN: begin
                    if (done) begin
                        state <= BROWSE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                    end
                end
                BROWSE: begin
                    if (key_evt[3]) begin
                        state <= LAUNCH;
                        go    <= 1'b1;
                        start <= {22'b0, sw};
                        n     <= '0;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                    end else if (key_evt[2]) begin
                        n <= '0;
                    end else if (key_evt[0] && !key_evt[1]) begin
                        n <= (n == N_LAST) ? '0 : n + 1'b1;
                    end else if (key_evt[1] && !key_evt[0]) begin
                        n <= (n == '0) ? N_LAST : n - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            disp_value <= start + 32'(n);
            // count already lags n by one cycle, so this lands two cycles after n moves.
            disp_iters <= (state == BROWSE) ? iters_sat : 16'd0;
        end
    end

endmodule

// File: tb/tb_collatz_run_ctrl.sv
// tb_collatz_run_ctrl
//   Directed bench for collatz_run_ctrl with short debounce and repeat
//   timings. A small RAM model answers each offset with a one-cycle latency;
//   all expected values below are worked out by hand from that model.
module tb_collatz_run_ctrl;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RPP = 8;

    logic        clk;
    logic        reset_n;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic        go;
    logic [31:0] start;
    logic        done;
    logic [7:0]  n;
    logic [15:0] count;
    logic [31:0] disp_value;
    logic [15:0] disp_iters;
    logic        busy;
    logic        valid;

    int n_vec  = 0;
    int n_miss = 0;
    int go_cnt = 0;
    int go_ref;

    collatz_run_ctrl #(
        .RAM_WORDS      (256),
        .RAM_ADDR_BITS  (8),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RPP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_n     (key_n),
        .sw        (sw),
        .go        (go),
        .start     (start),
        .done      (done),
        .n         (n),
        .count     (count),
        .disp_value(disp_value),
        .disp_iters(disp_iters),
        .busy      (busy),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result RAM model: offset 0 -> 112, offset 1 -> 0, otherwise offset+100.
    function automatic logic [15:0] ram_model(input logic [7:0] a);
        if (a == 8'd0) return 16'd112;
        if (a == 8'd1) return 16'd0;
        return 16'(a) + 16'd100;
    endfunction

    always @(posedge clk) count <= ram_model(n);

    always @(posedge clk) if (go === 1'b1) go_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Hold the masked keys for DB+3 cycles, then release long enough for the
    // release to be accepted as well.
    task automatic press_keys(input logic [3:0] mask);
        key_n = ~mask;
        tick(DB + 3);
        key_n = 4'hF;
        tick(10);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        key_n   = 4'hF;
        sw      = 10'd0;
        done    = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Reset state.
        check("rst_go",    go,         0);
        check("rst_start", start,      0);
        check("rst_n",     n,          0);
        check("rst_dval",  disp_value, 0);
        check("rst_diter", disp_iters, 0);
        check("rst_busy",  busy,       0);
        check("rst_valid", valid,      0);

        // Spurious done while idle.
        pulse_done();
        tick(2);
        check("idle_done_valid", valid,  0);
        check("idle_done_busy",  busy,   0);
        check("idle_done_go",    go_cnt, 0);

        // Launch from sw=27.
        sw = 10'd27;
        press_keys(4'b1000);
        check("launch_go_cnt", go_cnt,     1);
        check("launch_start",  start,      27);
        check("launch_busy",   busy,       1);
        check("launch_valid",  valid,      0);
        check("run_iters0",    disp_iters, 0);
        pulse_done();
        check("done_valid", valid, 1);
        check("done_busy",  busy,  0);
        check("done_n",     n,     0);
        tick(2);
        check("iters_n0", disp_iters, 111);
        check("dval_n0",  disp_value, 27);

        // Browse wrap and home.
        press_keys(4'b0010);
        check("prev_wrap_n",     n,          255);
        check("prev_wrap_dval",  disp_value, 282);
        check("prev_wrap_iters", disp_iters, 354);
        press_keys(4'b0001);
        check("next_wrap_n",     n,          0);
        check("next_wrap_iters", disp_iters, 111);
        press_keys(4'b0001);
        check("n1_sat_iters", disp_iters, 0);
        for (int i = 0; i < 4; i++) press_keys(4'b0001);
        check("n5",       n,          5);
        check("n5_iters", disp_iters, 104);
        check("n5_dval",  disp_value, 32);
        press_keys(4'b0100);
        check("home_n", n, 0);

        // Bounce then hold with auto-repeat.
        for (int i = 0; i < 10; i++) begin
            key_n[0] = 1'b0;
            tick(2);
            key_n[0] = 1'b1;
            tick(2);
        end
        check("bounce_n", n, 0);
        key_n[0] = 1'b0;
        tick(6);
        check("hold_pre_n", n, 0);
        tick(1);
        check("hold_first_n", n, 1);
        tick(19);
        check("rpt_pre_n", n, 1);
        tick(1);
        check("rpt_first_n", n, 2);
        tick(7);
        check("rpt_gap_n", n, 2);
        tick(1);
        check("rpt_second_n", n, 3);
        tick(8);
        check("rpt_third_n", n, 4);
        key_n[0] = 1'b1;
        tick(30);
        check("release_n", n, 4);

        // Simultaneous keys.
        press_keys(4'b0011);
        check("next_prev_n", n, 4);
        go_ref = go_cnt;
        sw = 10'd9;
        press_keys(4'b1001);
        check("run_next_go",    go_cnt - go_ref, 1);
        check("run_next_n",     n,               0);
        check("run_next_start", start,           9);
        check("run_next_busy",  busy,            1);
        pulse_done();
        tick(2);

        // Events ignored while running; nothing queued.
        go_ref = go_cnt;
        sw = 10'd100;
        press_keys(4'b1000);
        check("relaunch_go", go_cnt - go_ref, 1);
        sw = 10'd5;
        press_keys(4'b0001);
        check("run_key0_n", n, 0);
        press_keys(4'b1000);
        check("run_key3_go",    go_cnt - go_ref, 1);
        check("run_key3_start", start,           100);
        pulse_done();
        tick(20);
        check("after_done_go",    go_cnt - go_ref, 1);
        check("after_done_valid", valid,           1);
        check("after_done_dval",  disp_value,      100);
        check("after_done_iters", disp_iters,      111);

        // Reset in the middle of a run.
        press_keys(4'b1000);
        check("midrun_busy", busy, 1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("mr_go",    go,         0);
        check("mr_start", start,      0);
        check("mr_n",     n,          0);
        check("mr_dval",  disp_value, 0);
        check("mr_diter", disp_iters, 0);
        check("mr_busy",  busy,       0);
        check("mr_valid", valid,      0);
        pulse_done();
        tick(2);
        check("mr_done_valid", valid, 0);
        check("mr_done_busy",  busy,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
